// File: rtl/mem_arbiter.sv
// Two-requester (IF / LS) arbiter for a single memory port, one transaction in flight.
// Optional round-robin arbitration is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  output logic                    if_rsp_valid,
  input  logic                    if_rsp_ready,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,

  input  logic                    ls_req_valid,
  output logic                    ls_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ls_req_addr,
  input  logic                    ls_req_wen,
  input  logic [DATA_WIDTH-1:0]   ls_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_req_wmask,
  output logic                    ls_rsp_valid,
  input  logic                    ls_rsp_ready,
  output logic [DATA_WIDTH-1:0]   ls_rsp_data,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_rsp_valid,
  output logic                    mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);

  // state | meaning
  // IDLE  | waiting for a request; grant decided combinationally
  // REQ   | presenting latched request to memory
  // WAIT  | waiting for memory response / write ack
  // RESP  | returning response to the owner
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic                    owner_ls;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wen_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wmask_q;
  logic [DATA_WIDTH-1:0]   if_data_q;
  logic [DATA_WIDTH-1:0]   ls_data_q;
  logic                    grant_ls;
  logic                    grant_if;
  logic                    owner_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = LS was granted last, 0 = IF
  logic                    last_grant;

  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (ls_req_valid && if_req_valid) begin
      grant_ls = ~last_grant;
      grant_if = last_grant;
    end else begin
      grant_ls = ls_req_valid;
      grant_if = if_req_valid;
    end
  end
`else
  always_comb begin
    grant_ls = ls_req_valid;
    grant_if = if_req_valid && !ls_req_valid;
  end
`endif

  // Handshake outputs are forced low while reset is held
  assign if_req_ready  = !rst && (state == S_IDLE) && grant_if;
  assign ls_req_ready  = !rst && (state == S_IDLE) && grant_ls;
  assign mem_req_valid = !rst && (state == S_REQ);
  assign mem_rsp_ready = !rst && (state == S_WAIT);
  assign if_rsp_valid  = !rst && (state == S_RESP) && !owner_ls;
  assign ls_rsp_valid  = !rst && (state == S_RESP) && owner_ls;

  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign if_rsp_data   = if_data_q;
  assign ls_rsp_data   = ls_data_q;

  assign owner_done = owner_ls ? ls_rsp_ready : if_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner_ls  <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      if_data_q <= '0;
      ls_data_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_ls) begin
            owner_ls <= 1'b1;
            addr_q   <= ls_req_addr;
            wen_q    <= ls_req_wen;
            wdata_q  <= ls_req_wdata;
            wmask_q  <= ls_req_wmask;
            state    <= S_REQ;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
          end else if (grant_if) begin
            // fetch is read-only
            owner_ls <= 1'b0;
            addr_q   <= if_req_addr;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            state    <= S_REQ;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
          end
        end
        S_REQ: begin
          if (mem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (owner_ls) ls_data_q <= mem_rsp_data;
            else          if_data_q <= mem_rsp_data;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (owner_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
